// File: rtl/eggtimer_ctrl.sv
// Egg timer control FSM: owns the programmed BCD cook time, sequences the
// countdown counter (load/enable), and drives display select, LEDs and alarm.
module eggtimer_ctrl #(
  parameter int unsigned ALARM_SECONDS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse_1s,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_sec_inc,
  input  logic       btn_min_inc,
  input  logic       count_zero,
  output logic [3:0] seconds_prog,
  output logic [3:0] tens_seconds_prog,
  output logic [3:0] minutes_prog,
  output logic [3:0] tens_minutes_prog,
  output logic       load_count,
  output logic       count_en,
  output logic       display_prog,
  output logic       timer_enabled_led,
  output logic       timer_on_led,
  output logic       alarm,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_PROG  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_ALARM = 2'd3;

  localparam logic [3:0] ALARM_LAST = 4'(ALARM_SECONDS - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] sec_u_q, sec_u_d;
  logic [3:0] sec_t_q, sec_t_d;
  logic [3:0] min_u_q, min_u_d;
  logic [3:0] min_t_q, min_t_d;
  logic       load_q, load_d;
  logic       flash_q, flash_d;
  logic [3:0] alarm_cnt_q, alarm_cnt_d;

  logic any_btn;
  logic prog_nonzero;

  assign any_btn      = btn_start | btn_clear | btn_sec_inc | btn_min_inc;
  assign prog_nonzero = |{sec_u_q, sec_t_q, min_u_q, min_t_q};

  always_comb begin
    state_d     = state_q;
    sec_u_d     = sec_u_q;
    sec_t_d     = sec_t_q;
    min_u_d     = min_u_q;
    min_t_d     = min_t_q;
    load_d      = 1'b0;
    flash_d     = flash_q;
    alarm_cnt_d = alarm_cnt_q;

    case (state_q)
      S_PROG: begin
        if (btn_clear) begin
          sec_u_d = 4'd0;
          sec_t_d = 4'd0;
          min_u_d = 4'd0;
          min_t_d = 4'd0;
        end else if (btn_start) begin
          // A zero cook time has nothing to count down, so start is swallowed.
          if (prog_nonzero) begin
            state_d = S_RUN;
            load_d  = 1'b1;
            flash_d = 1'b1;
          end
        end else begin
          if (btn_sec_inc) begin
            if (sec_u_q == 4'd9) begin
              sec_u_d = 4'd0;
              sec_t_d = (sec_t_q == 4'd5) ? 4'd0 : sec_t_q + 4'd1;
            end else begin
              sec_u_d = sec_u_q + 4'd1;
            end
          end
          if (btn_min_inc) begin
            if (min_u_q == 4'd9) begin
              min_u_d = 4'd0;
              min_t_d = (min_t_q == 4'd9) ? 4'd0 : min_t_q + 4'd1;
            end else begin
              min_u_d = min_u_q + 4'd1;
            end
          end
        end
      end

      S_RUN: begin
        flash_d = flash_q ^ pulse_1s;
        // During the load cycle the counter still shows its old value.
        if (btn_clear) begin
          state_d = S_PROG;
        end else if (count_zero && !load_q) begin
          state_d     = S_ALARM;
          alarm_cnt_d = 4'd0;
        end else if (btn_start) begin
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (btn_clear) begin
          state_d = S_PROG;
        end else if (btn_start) begin
          state_d = S_RUN;
          flash_d = 1'b1;
        end
      end

      S_ALARM: begin
        if (any_btn) begin
          state_d = S_PROG;
        end else if (pulse_1s) begin
          alarm_cnt_d = alarm_cnt_q + 4'd1;
          if (alarm_cnt_q == ALARM_LAST) begin
            state_d = S_PROG;
          end
        end
      end

      default: state_d = S_PROG;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_PROG;
      sec_u_q     <= 4'd0;
      sec_t_q     <= 4'd0;
      min_u_q     <= 4'd0;
      min_t_q     <= 4'd0;
      load_q      <= 1'b0;
      flash_q     <= 1'b0;
      alarm_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      sec_u_q     <= sec_u_d;
      sec_t_q     <= sec_t_d;
      min_u_q     <= min_u_d;
      min_t_q     <= min_t_d;
      load_q      <= load_d;
      flash_q     <= flash_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign seconds_prog      = sec_u_q;
  assign tens_seconds_prog = sec_t_q;
  assign minutes_prog      = min_u_q;
  assign tens_minutes_prog = min_t_q;
  assign load_count        = load_q;
  assign count_en          = (state_q == S_RUN) && !load_q;
  assign display_prog      = (state_q == S_PROG);
  assign timer_enabled_led = (state_q != S_PROG);
  assign timer_on_led      = ((state_q == S_RUN) && flash_q) || (state_q == S_PAUSE);
  assign alarm             = (state_q == S_ALARM);
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_eggtimer_ctrl.sv
// Bench for eggtimer_ctrl: directed scenarios plus randomized buttons/ticks,
// checked every cycle against a behavioural model working in whole seconds/minutes.
module tb_eggtimer_ctrl;

  localparam int ALARM_S = 10;
  localparam int M_PROG  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ALARM = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pulse_1s = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_sec_inc = 1'b0;
  logic       btn_min_inc = 1'b0;
  logic       count_zero = 1'b0;
  logic [3:0] seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog;
  logic       load_count, count_en, display_prog;
  logic       timer_enabled_led, timer_on_led, alarm;
  logic [1:0] dbg_state;
  logic [21:0] dut_vec;

  int checks = 0;
  int errors = 0;

  int m_mode, m_sec, m_min, m_ticks;
  bit m_load, m_flash;

  eggtimer_ctrl #(.ALARM_SECONDS(ALARM_S)) dut (
    .clk               (clk),
    .reset             (reset),
    .pulse_1s          (pulse_1s),
    .btn_start         (btn_start),
    .btn_clear         (btn_clear),
    .btn_sec_inc       (btn_sec_inc),
    .btn_min_inc       (btn_min_inc),
    .count_zero        (count_zero),
    .seconds_prog      (seconds_prog),
    .tens_seconds_prog (tens_seconds_prog),
    .minutes_prog      (minutes_prog),
    .tens_minutes_prog (tens_minutes_prog),
    .load_count        (load_count),
    .count_en          (count_en),
    .display_prog      (display_prog),
    .timer_enabled_led (timer_enabled_led),
    .timer_on_led      (timer_on_led),
    .alarm             (alarm),
    .dbg_state         (dbg_state)
  );

  always #5 clk = ~clk;

  assign dut_vec = {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog,
                    load_count, count_en, display_prog, timer_enabled_led,
                    timer_on_led, alarm};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_PROG;
    m_sec   = 0;
    m_min   = 0;
    m_ticks = 0;
    m_load  = 1'b0;
    m_flash = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit cl, input bit si, input bit mi,
                            input bit p, input bit cz);
    bit was_load;
    bit any;
    was_load = m_load;
    any      = st | cl | si | mi;
    m_load   = 1'b0;
    case (m_mode)
      M_PROG: begin
        if (cl) begin
          m_sec = 0;
          m_min = 0;
        end else if (st) begin
          if (m_min * 60 + m_sec > 0) begin
            m_mode  = M_RUN;
            m_load  = 1'b1;
            m_flash = 1'b1;
          end
        end else begin
          if (si) m_sec = (m_sec + 1) % 60;
          if (mi) m_min = (m_min + 1) % 100;
        end
      end
      M_RUN: begin
        if (p) m_flash = !m_flash;
        if (cl) m_mode = M_PROG;
        else if (cz && !was_load) begin
          m_mode  = M_ALARM;
          m_ticks = 0;
        end else if (st) m_mode = M_PAUSE;
      end
      M_PAUSE: begin
        if (cl) m_mode = M_PROG;
        else if (st) begin
          m_mode  = M_RUN;
          m_flash = 1'b1;
        end
      end
      default: begin
        if (any) m_mode = M_PROG;
        else if (p) begin
          m_ticks++;
          if (m_ticks >= ALARM_S) m_mode = M_PROG;
        end
      end
    endcase
  endtask

  function automatic logic [21:0] model_vec();
    logic [3:0] mt, mu, st, su;
    mt = 4'(m_min / 10);
    mu = 4'(m_min % 10);
    st = 4'(m_sec / 10);
    su = 4'(m_sec % 10);
    return {mt, mu, st, su, m_load, (m_mode == M_RUN) && !m_load, m_mode == M_PROG,
            m_mode != M_PROG, ((m_mode == M_RUN) && m_flash) || (m_mode == M_PAUSE),
            m_mode == M_ALARM};
  endfunction

  // One clock: drive inputs for this cycle, advance model at the edge, compare 1 ns later.
  task automatic cycle(input string tag, input bit st, input bit cl, input bit si,
                       input bit mi, input bit p, input bit cz);
    btn_start   = st;
    btn_clear   = cl;
    btn_sec_inc = si;
    btn_min_inc = mi;
    pulse_1s    = p;
    count_zero  = cz;
    @(posedge clk);
    model_step(st, cl, si, mi, p, cz);
    #1;
    check_eq(tag, 32'(dut_vec), 32'(model_vec()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle("idle", 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : main
    logic [1:0] dbg_prog, dbg_run;
    int r;
    bit p, cz;

    model_reset();
    #12;
    check_eq("reset_vec", 32'(dut_vec), 32'(model_vec()));
    check_eq("reset_disp", 32'(display_prog), 32'd1);
    #10;
    reset = 1'b0;

    // Seconds wrap 59->00 without carrying into minutes; minutes wrap 99->00.
    for (int i = 0; i < 61; i++) cycle("sec_inc", 0, 0, 1, 0, 0, 0);
    check_eq("sec_wrap", 32'({tens_seconds_prog, seconds_prog}), 32'h01);
    check_eq("sec_no_carry", 32'({tens_minutes_prog, minutes_prog}), 32'h00);
    for (int i = 0; i < 100; i++) cycle("min_inc", 0, 0, 0, 1, 0, 0);
    check_eq("min_wrap", 32'({tens_minutes_prog, minutes_prog}), 32'h00);
    check_eq("sec_kept", 32'({tens_seconds_prog, seconds_prog}), 32'h01);
    cycle("both_inc", 0, 0, 1, 1, 0, 0);
    check_eq("both_inc_val", 32'({tens_minutes_prog, minutes_prog, tens_seconds_prog,
                                  seconds_prog}), 32'h0102);
    cycle("clear", 0, 1, 0, 0, 0, 0);
    check_eq("clear_val", 32'({tens_minutes_prog, minutes_prog, tens_seconds_prog,
                               seconds_prog}), 32'h0000);

    // Start with 00:00 is ignored.
    cycle("start_zero", 1, 0, 0, 0, 0, 0);
    check_eq("start_zero_load", 32'(load_count), 32'd0);
    check_eq("start_zero_prog", 32'(display_prog), 32'd1);
    dbg_prog = dbg_state;

    // Program 00:03 and run; count_zero during the load cycle is stale.
    for (int i = 0; i < 3; i++) cycle("prog3", 0, 0, 1, 0, 0, 0);
    cycle("start", 1, 0, 0, 0, 0, 0);
    check_eq("load_1st", 32'({load_count, count_en}), 32'b10);
    dbg_run = dbg_state;
    check_eq("dbg_distinct", 32'(dbg_prog != dbg_run), 32'd1);
    cycle("load_cz", 0, 0, 0, 0, 0, 1);
    check_eq("load_done", 32'({load_count, count_en, alarm}), 32'b010);
    check_eq("flash_on", 32'(timer_on_led), 32'd1);
    cycle("tick1", 0, 0, 0, 0, 1, 0);
    check_eq("flash_tog1", 32'(timer_on_led), 32'd0);
    cycle("tick2", 0, 0, 0, 0, 1, 0);
    check_eq("flash_tog2", 32'(timer_on_led), 32'd1);

    // count_zero beats btn_start; alarm lasts ALARM_S ticks.
    cycle("cz_start", 1, 0, 0, 0, 0, 1);
    check_eq("alarm_in", 32'({alarm, count_en, display_prog}), 32'b100);
    for (int k = 1; k <= ALARM_S; k++) begin
      idle(2);
      cycle("alarm_tick", 0, 0, 0, 0, 1, 0);
      check_eq("alarm_lvl", 32'(alarm), (k < ALARM_S) ? 32'd1 : 32'd0);
    end
    check_eq("alarm_exit_prog", 32'(display_prog), 32'd1);
    check_eq("alarm_digits", 32'({tens_minutes_prog, minutes_prog, tens_seconds_prog,
                                  seconds_prog}), 32'h0003);

    // Pause / resume / clear+start.
    cycle("start2", 1, 0, 0, 0, 0, 0);
    idle(2);
    cycle("pause", 1, 0, 0, 0, 0, 0);
    check_eq("pause_out", 32'({count_en, timer_on_led, display_prog}), 32'b010);
    cycle("resume", 1, 0, 0, 0, 0, 0);
    check_eq("resume_out", 32'({load_count, count_en, timer_on_led}), 32'b011);
    cycle("pause2", 1, 0, 0, 0, 0, 0);
    cycle("clr_start", 1, 1, 0, 0, 0, 0);
    check_eq("clr_start_prog", 32'(display_prog), 32'd1);
    check_eq("clr_keep", 32'({tens_minutes_prog, minutes_prog, tens_seconds_prog,
                              seconds_prog}), 32'h0003);

    // Asynchronous reset in the middle of a run.
    cycle("start3", 1, 0, 0, 0, 0, 0);
    idle(3);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("reset_mid_run", 32'(dut_vec), 32'(model_vec()));
    check_eq("reset_mid_led", 32'({timer_enabled_led, timer_on_led, alarm}), 32'b000);
    #2;
    reset = 1'b0;

    // Randomized traffic; one button per cycle except the start+clear and sec+min combos.
    for (int n = 0; n < 4000; n++) begin
      r  = $urandom_range(0, 15);
      p  = ($urandom_range(0, 5) == 0);
      cz = ($urandom_range(0, 11) == 0);
      case (r)
        0, 1:    cycle("rnd", 1, 0, 0, 0, p, cz);
        2:       cycle("rnd", 0, 1, 0, 0, p, cz);
        3, 4:    cycle("rnd", 0, 0, 1, 0, p, cz);
        5:       cycle("rnd", 0, 0, 0, 1, p, cz);
        6:       cycle("rnd", 0, 0, 1, 1, p, cz);
        7:       cycle("rnd", 1, 1, 0, 0, p, cz);
        default: cycle("rnd", 0, 0, 0, 0, p, cz);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eggtimer_ctrl.md
Name: eggtimer_ctrl

Overview:
Control state machine for the egg timer. It owns the programmed cook time as four BCD digits and handles the user buttons. It sequences the countdown counter with load and enable strobes, drives the display-mux select, the status LEDs and the alarm. It sits between the debounced button inputs, the 1 s tick generator, the time counter and the display mux.

Parameters:
ALARM_SECONDS, 10, number of pulse_1s ticks the alarm stays active before returning to PROG; legal range 1..15.

Ports:
clk  input  1  system clock (5 MHz domain)
reset  input  1  asynchronous, active-high reset
pulse_1s  input  1  single-cycle tick, once per second
btn_start  input  1  single-cycle pulse, debounced start/pause
btn_clear  input  1  single-cycle pulse, debounced clear/abort
btn_sec_inc  input  1  single-cycle pulse, increment programmed seconds
btn_min_inc  input  1  single-cycle pulse, increment programmed minutes
count_zero  input  1  counter reads 00:00
seconds_prog  output  4  programmed seconds units (BCD 0-9)
tens_seconds_prog  output  4  programmed seconds tens (BCD 0-5)
minutes_prog  output  4  programmed minutes units (BCD 0-9)
tens_minutes_prog  output  4  programmed minutes tens (BCD 0-9)
load_count  output  1  one-cycle strobe: counter loads the *_prog digits
count_en  output  1  counter decrements on pulse_1s while high
display_prog  output  1  1 = display shows programmed time, 0 = live count
timer_enabled_led  output  1  high in any state except PROG
timer_on_led  output  1  flashes at 0.5 Hz in RUN, solid in PAUSE
alarm  output  1  high in ALARM state

Behaviour:
- All outputs are registered or decoded from registered state. No combinational input-to-output paths.
- Reset (async, any time, including mid-run or mid-alarm) forces:
  - state = PROG and all *_prog digits = 0
  - load_count = 0, count_en = 0, display_prog = 1
  - both LEDs = 0, alarm = 0, flash register = 0, alarm counter = 0
- States: PROG, RUN, PAUSE, ALARM.
- Button priority within one cycle: clear > start > inc. btn_sec_inc and btn_min_inc may both act in the same cycle.
- PROG:
  - display_prog = 1, count_en = 0.
  - btn_sec_inc: seconds go 00→01→…→59→00. Units wrap 9→0 and carry into tens. Tens wrap 5→0. No carry into minutes.
  - btn_min_inc: minutes go 00→…→99→00. Units wrap 9→0 and carry into tens; tens wrap 9→0.
  - btn_clear: all four *_prog digits set to 0.
  - btn_start with nonzero programmed time: next state RUN, and load_count = 1 for exactly the first RUN cycle.
  - btn_start with programmed time 00:00: ignored, stay in PROG.
- RUN:
  - display_prog = 0.
  - count_en = 1, except in the load_count cycle, where it is 0.
  - count_zero is ignored during the load_count cycle (stale counter value).
  - Priority: btn_clear → PROG (*_prog digits retained), then count_zero → ALARM, then btn_start → PAUSE.
  - Inc buttons are ignored.
  - Flash register is set to 1 on RUN entry from PROG and toggles on each pulse_1s. timer_on_led = flash.
- PAUSE:
  - count_en = 0, display_prog = 0, timer_on_led = 1.
  - btn_clear → PROG. btn_start → RUN, with no load strobe and flash reset to 1.
  - Inc buttons are ignored.
- ALARM:
  - alarm = 1, count_en = 0, display_prog = 0, timer_on_led = 0.
  - Alarm counter clears on entry and increments on each pulse_1s.
  - When the counter reaches ALARM_SECONDS, or on any button pulse, next state is PROG.
  - *_prog digits are retained, so the same time can be restarted.
- timer_enabled_led = (state != PROG).
- All state changes take effect on the clock edge after the causing input. Outputs change in that same cycle.

Test Plan:
- Reset mid-RUN → next sample shows state PROG, all digits 0, display_prog = 1, count_en = 0, both LEDs 0, alarm 0.
- In PROG, 61 btn_sec_inc pulses → seconds read 01 (wrapped at 59→00). 100 btn_min_inc pulses → minutes read 00. Minutes unchanged by the seconds wrap.
- Program 00:03, pulse btn_start → load_count high for exactly 1 cycle, then count_en high. timer_on_led toggles on each pulse_1s.
- btn_start in PROG at 00:00 → no state change and no load_count.
- In RUN, assert count_zero and btn_start in the same cycle → ALARM (count_zero wins). alarm stays high for 10 pulse_1s ticks, then PROG with digits retained.
- In RUN, btn_start → PAUSE (count_en 0, LED solid 1). btn_start → RUN with no load_count. btn_clear with btn_start in the same cycle → PROG.
